// File: rtl/audio_dma_pkg.sv
// Shared constants and FSM state type for the multi-channel audio DMA reader.
package audio_dma_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_REMAIN = 2'd2;
  localparam logic [1:0] REG_BASE   = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_LOOP = 2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } dma_state_e;

endpackage

// File: rtl/audio_dma_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible whenever not empty.
module audio_dma_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  assign count    = wptr - rptr;
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = wptr == rptr;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_dma_reader.sv
// NCHAN-channel WISHBONE DMA reader feeding a shared tagged sample FIFO.
// Define AUDIO_DMA_LOOP_EN to add per-channel BASE register and CTRL.LOOP circular mode.
module audio_dma_reader
  import audio_dma_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         NCHAN    = 2,
  parameter int         DEPTH    = 16,
  parameter int         CW       = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [13:0]       csr_a,
  input  logic              csr_we,
  input  logic [31:0]       csr_di,
  output logic [31:0]       csr_do,
  output logic [NCHAN-1:0]  irq,
  output logic [31:0]       wbm_adr_o,
  output logic [2:0]        wbm_cti_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_chan,
  output logic [31:0]       out_data
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  dma_state_e state, state_n;
  logic                    issue, done;
  logic [CW-1:0]           cur, rr, pick;
  logic [31:0]             pick_addr;

  logic [NCHAN-1:0]        en, elig, hit, wr_sel;
  logic [NCHAN-1:0][31:0]  addr, remain;
`ifdef AUDIO_DMA_LOOP_EN
  logic [NCHAN-1:0]        loop;
  logic [NCHAN-1:0][31:0]  base, reload;
`endif

  logic                    csr_sel;
  logic [7:0]              csr_ch;
  logic [1:0]              csr_off;
  logic [31:0]             rd;

  logic                    fifo_full, fifo_empty;
  logic [CNTW-1:0]         fifo_count;
  logic [CW+31:0]          fifo_head;

  assign csr_sel = csr_a[13:10] == csr_addr;
  assign csr_ch  = csr_a[9:2];
  assign csr_off = csr_a[1:0];

  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = state == S_FETCH;
  assign wbm_stb_o = state == S_FETCH;

  always_comb begin
    for (int n = 0; n < NCHAN; n++) begin
      elig[n]   = en[n] && (remain[n] != 32'd0);
      hit[n]    = done && (cur == CW'(n));
      wr_sel[n] = csr_we && csr_sel && (csr_ch == 8'(n));
    end
  end

  // Round robin: the eligible channel closest at or after rr wins.
  always_comb begin
    int best, d;
    best      = NCHAN;
    d         = 0;
    pick      = '0;
    pick_addr = '0;
    for (int n = 0; n < NCHAN; n++) begin
      d = (n + NCHAN - int'(rr)) % NCHAN;
      if (elig[n] && d < best) begin
        best      = d;
        pick      = CW'(n);
        pick_addr = addr[n];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  // Issuing only with a free entry reserves room for the in-flight ack.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (|elig && fifo_count != CNTW'(DEPTH)) begin
          issue   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (wbm_ack_i) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur       <= '0;
      rr        <= '0;
      wbm_adr_o <= '0;
    end else if (issue) begin
      cur       <= pick;
      wbm_adr_o <= pick_addr;
      rr        <= (pick == CW'(NCHAN-1)) ? '0 : pick + CW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en     <= '0;
      addr   <= '0;
      remain <= '0;
      irq    <= '0;
`ifdef AUDIO_DMA_LOOP_EN
      loop   <= '0;
      base   <= '0;
      reload <= '0;
`endif
    end else begin
      irq <= '0;
      for (int n = 0; n < NCHAN; n++) begin
        if (wr_sel[n]) begin
          case (csr_off)
            REG_CTRL: begin
              en[n] <= csr_di[CTRL_EN];
`ifdef AUDIO_DMA_LOOP_EN
              loop[n] <= csr_di[CTRL_LOOP];
`endif
            end
            REG_ADDR:   if (!en[n]) addr[n] <= {csr_di[31:2], 2'b00};
            REG_REMAIN: if (!en[n]) begin
              remain[n] <= csr_di;
`ifdef AUDIO_DMA_LOOP_EN
              reload[n] <= csr_di;
`endif
            end
            REG_BASE: begin
`ifdef AUDIO_DMA_LOOP_EN
              base[n] <= {csr_di[31:2], 2'b00};
`endif
            end
          endcase
        end
        // Ack update lands after the CSR write so it wins on the same edge.
        if (hit[n]) begin
          addr[n] <= addr[n] + 32'd4;
          if (remain[n] != 32'd0) remain[n] <= remain[n] - 32'd1;
          if (remain[n] == 32'd1) begin
            irq[n] <= 1'b1;
`ifdef AUDIO_DMA_LOOP_EN
            if (loop[n]) begin
              addr[n]   <= base[n];
              remain[n] <= reload[n];
            end else begin
              en[n] <= 1'b0;
            end
`else
            en[n] <= 1'b0;
`endif
          end
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int n = 0; n < NCHAN; n++) begin
      if (csr_sel && csr_ch == 8'(n)) begin
        case (csr_off)
          REG_CTRL: begin
            rd[CTRL_EN]   = en[n];
            rd[CTRL_BUSY] = wbm_cyc_o && (cur == CW'(n));
`ifdef AUDIO_DMA_LOOP_EN
            rd[CTRL_LOOP] = loop[n];
`else
            rd[CTRL_LOOP] = 1'b0;
`endif
          end
          REG_ADDR:   rd = addr[n];
          REG_REMAIN: rd = remain[n];
`ifdef AUDIO_DMA_LOOP_EN
          REG_BASE:   rd = base[n];
`else
          REG_BASE:   rd = '0;
`endif
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) csr_do <= '0;
    else         csr_do <= rd;
  end

  audio_dma_fifo #(
    .W     (CW + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (done && !fifo_full),
    .push_data ({cur, wbm_dat_i}),
    .pop       (out_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid           = !fifo_empty;
  assign {out_chan, out_data} = fifo_head;

endmodule

// File: tb/tb_audio_dma_reader.sv
// Directed self-checking bench for audio_dma_reader (2 channels, 4-deep FIFO).
module tb_audio_dma_reader;

  localparam int NCHAN = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [13:0]       csr_a = '0;
  logic              csr_we = 1'b0;
  logic [31:0]       csr_di = '0;
  logic [31:0]       csr_do;
  logic [NCHAN-1:0]  irq;
  logic [31:0]       wbm_adr_o;
  logic [2:0]        wbm_cti_o;
  logic              wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic              wbm_ack_i = 1'b0;
  logic [31:0]       wbm_dat_i;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CW-1:0]     out_chan;
  logic [31:0]       out_data;

  int checks = 0;
  int passed = 0;

  logic [31:0]    wb_log[$];
  logic [CW+31:0] st_log[$];
  int             irq_cnt[NCHAN];
  logic           stall = 1'b0;
  logic           force_ack = 1'b0;

  audio_dma_reader #(
    .csr_addr (4'h0),
    .NCHAN    (NCHAN),
    .DEPTH    (DEPTH),
    .CW       (CW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .irq       (irq),
    .wbm_adr_o (wbm_adr_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_data  (out_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Memory returns the word address as data, acking one cycle after stb.
  assign wbm_dat_i = wbm_adr_o;

  always @(negedge sys_clk) begin
    if (out_valid && out_ready) st_log.push_back({out_chan, out_data});
    for (int i = 0; i < NCHAN; i++) if (irq[i]) irq_cnt[i]++;
    if (force_ack) wbm_ack_i = 1'b1;
    else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !stall) begin
      wbm_ack_i = 1'b1;
      wb_log.push_back(wbm_adr_o);
    end else wbm_ack_i = 1'b0;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [13:0] ra(input int ch, input int off);
    return 14'(ch * 4 + off);
  endfunction

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
    csr_a = a;
    tick();
    d = csr_do;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (wb_log.size() < n && k < budget) begin tick(); k++; end
    checks++;
    if (wb_log.size() < n) $display("FAIL %s timeout: got %0d txns want %0d", name, wb_log.size(), n);
    else passed++;
  endtask

  task automatic wait_stb(input int budget, input string name);
    int k = 0;
    while (!wbm_stb_o && k < budget) begin tick(); k++; end
    checks++;
    if (!wbm_stb_o) $display("FAIL %s stb timeout after %0d cycles", name, k);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    checks++; if ({wbm_cyc_o, wbm_stb_o, out_valid} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {wbm_cyc_o, wbm_stb_o, out_valid}); else passed++;
    checks++; if (wbm_adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", wbm_adr_o); else passed++;
    checks++; if (irq !== '0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
    checks++; if (csr_do !== 32'h0) $display("FAIL reset_csr_do: got %h want 0", csr_do); else passed++;
    checks++; if ({wbm_cti_o, wbm_we_o} !== 4'b0000) $display("FAIL reset_cti_we: got %b want 0000", {wbm_cti_o, wbm_we_o}); else passed++;
    csr_rd(ra(1, 2), d);
    checks++; if (d !== 32'h0) $display("FAIL reset_remain1: got %h want 0", d); else passed++;
  endtask

  task automatic test_csr();
    logic [31:0] d;
    csr_wr(ra(0, 1), 32'h123);
    csr_rd(ra(0, 1), d);
    checks++; if (d !== 32'h120) $display("FAIL csr_addr_align: got %h want 120", d); else passed++;
    csr_wr(14'h400 | ra(0, 1), 32'hFFF0);
    csr_rd(ra(0, 1), d);
    checks++; if (d !== 32'h120) $display("FAIL csr_other_page_wr: got %h want 120", d); else passed++;
    csr_rd(14'h400 | ra(0, 1), d);
    checks++; if (d !== 32'h0) $display("FAIL csr_other_page_rd: got %h want 0", d); else passed++;
    csr_wr(ra(2, 1), 32'h55);
    csr_rd(ra(2, 1), d);
    checks++; if (d !== 32'h0) $display("FAIL csr_unmapped_ch: got %h want 0", d); else passed++;
    csr_wr(ra(0, 3), 32'h80);
    csr_rd(ra(0, 3), d);
`ifdef AUDIO_DMA_LOOP_EN
    checks++; if (d !== 32'h80) $display("FAIL csr_base: got %h want 80", d); else passed++;
`else
    checks++; if (d !== 32'h0) $display("FAIL csr_base: got %h want 0", d); else passed++;
`endif
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic [CW+31:0] e;
    int s = wb_log.size();
    int ss = st_log.size();
    int i0 = irq_cnt[0];
    csr_wr(ra(0, 1), 32'h100);
    csr_wr(ra(0, 2), 32'd3);
    csr_wr(ra(0, 0), 32'h1);
    wait_log(s + 3, 100, "single");
    repeat (10) tick();
    checks++; if (wb_log.size() !== s + 3) $display("FAIL single_count: got %0d want %0d", wb_log.size(), s + 3); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_log[s+i] !== 32'h100 + 32'(4*i)) $display("FAIL single_adr%0d: got %h want %h", i, wb_log[s+i], 32'h100 + 32'(4*i)); else passed++;
      e = {2'd0, 32'h100 + 32'(4*i)};
      checks++; if (st_log.size() <= ss + i || st_log[ss+i] !== e) $display("FAIL single_stream%0d: got %h want %h", i, (st_log.size() > ss + i) ? st_log[ss+i] : 'x, e); else passed++;
    end
    checks++; if (irq_cnt[0] - i0 !== 1) $display("FAIL single_irq: got %0d pulses want 1", irq_cnt[0] - i0); else passed++;
    csr_rd(ra(0, 0), d);
    checks++; if (d !== 32'h0) $display("FAIL single_ctrl: got %h want 0", d); else passed++;
    csr_rd(ra(0, 1), d);
    checks++; if (d !== 32'h10C) $display("FAIL single_addr_end: got %h want 10c", d); else passed++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_a[4];
    int s = wb_log.size();
    int i1 = irq_cnt[1];
    exp_a = '{32'h1000, 32'h2000, 32'h1004, 32'h2004};
    csr_wr(ra(0, 1), 32'h1000);
    csr_wr(ra(0, 2), 32'd2);
    csr_wr(ra(1, 1), 32'h2000);
    csr_wr(ra(1, 2), 32'd2);
    csr_wr(ra(0, 0), 32'h1);
    csr_wr(ra(1, 0), 32'h1);
    wait_log(s + 4, 100, "rr");
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_log.size() <= s + i || wb_log[s+i] !== exp_a[i]) $display("FAIL rr_adr%0d: got %h want %h", i, (wb_log.size() > s + i) ? wb_log[s+i] : 'x, exp_a[i]); else passed++;
    end
    checks++; if (irq_cnt[1] - i1 !== 1) $display("FAIL rr_irq1: got %0d want 1", irq_cnt[1] - i1); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [CW+31:0] e;
    int s = wb_log.size();
    int ss = st_log.size();
    out_ready = 1'b0;
    csr_wr(ra(0, 1), 32'h3000);
    csr_wr(ra(0, 2), 32'd10);
    csr_wr(ra(0, 0), 32'h1);
    wait_log(s + 4, 100, "bp_fill");
    repeat (30) tick();
    checks++; if (wb_log.size() !== s + 4) $display("FAIL bp_stalled_count: got %0d want %0d", wb_log.size(), s + 4); else passed++;
    checks++; if ({wbm_cyc_o, out_valid} !== 2'b01) $display("FAIL bp_cyc_valid: got %b want 01", {wbm_cyc_o, out_valid}); else passed++;
    csr_rd(ra(0, 2), d);
    checks++; if (d !== 32'd6) $display("FAIL bp_remain: got %0d want 6", d); else passed++;
    out_ready = 1'b1;
    wait_log(s + 10, 300, "bp_drain");
    repeat (10) tick();
    checks++; if (st_log.size() - ss !== 10) $display("FAIL bp_stream_count: got %0d want 10", st_log.size() - ss); else passed++;
    for (int i = 0; i < 10; i += 3) begin
      e = {2'd0, 32'h3000 + 32'(4*i)};
      checks++; if (st_log.size() <= ss + i || st_log[ss+i] !== e) $display("FAIL bp_stream%0d: got %h want %h", i, (st_log.size() > ss + i) ? st_log[ss+i] : 'x, e); else passed++;
    end
  endtask

  task automatic test_disable_mid();
    logic [31:0] d;
    int s = wb_log.size();
    int i1 = irq_cnt[1];
    stall = 1'b1;
    csr_wr(ra(1, 1), 32'h500);
    csr_wr(ra(1, 2), 32'd5);
    csr_wr(ra(1, 0), 32'h1);
    wait_stb(20, "dis_stb");
    csr_rd(ra(1, 0), d);
    checks++; if (d !== 32'h3) $display("FAIL dis_busy_en: got %h want 3", d); else passed++;
    csr_wr(ra(1, 0), 32'h0);
    csr_rd(ra(1, 0), d);
    checks++; if (d !== 32'h2) $display("FAIL dis_busy_only: got %h want 2", d); else passed++;
    stall = 1'b0;
    repeat (20) tick();
    checks++; if (wb_log.size() !== s + 1) $display("FAIL dis_count: got %0d want %0d", wb_log.size(), s + 1); else passed++;
    csr_rd(ra(1, 2), d);
    checks++; if (d !== 32'd4) $display("FAIL dis_remain: got %0d want 4", d); else passed++;
    csr_rd(ra(1, 1), d);
    checks++; if (d !== 32'h504) $display("FAIL dis_addr: got %h want 504", d); else passed++;
    checks++; if (irq_cnt[1] - i1 !== 0) $display("FAIL dis_irq: got %0d want 0", irq_cnt[1] - i1); else passed++;
  endtask

  task automatic test_en_no_remain();
    logic [31:0] d;
    int s = wb_log.size();
    int i0 = irq_cnt[0];
    csr_wr(ra(0, 0), 32'h5);
    repeat (10) tick();
    checks++; if (wb_log.size() !== s) $display("FAIL zero_rem_txn: got %0d want %0d", wb_log.size(), s); else passed++;
    csr_rd(ra(0, 0), d);
`ifdef AUDIO_DMA_LOOP_EN
    checks++; if (d !== 32'h5) $display("FAIL zero_rem_ctrl: got %h want 5", d); else passed++;
`else
    checks++; if (d !== 32'h1) $display("FAIL zero_rem_ctrl: got %h want 1", d); else passed++;
`endif
    checks++; if (irq_cnt[0] - i0 !== 0) $display("FAIL zero_rem_irq: got %0d want 0", irq_cnt[0] - i0); else passed++;
    csr_wr(ra(0, 0), 32'h0);
  endtask

`ifdef AUDIO_DMA_LOOP_EN
  task automatic test_loop();
    logic [31:0] d;
    logic [31:0] exp_a[5];
    int s = wb_log.size();
    int i0 = irq_cnt[0];
    exp_a = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40};
    csr_wr(ra(0, 3), 32'h40);
    csr_wr(ra(0, 1), 32'h40);
    csr_wr(ra(0, 2), 32'd2);
    csr_wr(ra(0, 0), 32'h5);
    wait_log(s + 5, 100, "loop");
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (wb_log.size() <= s + i || wb_log[s+i] !== exp_a[i]) $display("FAIL loop_adr%0d: got %h want %h", i, (wb_log.size() > s + i) ? wb_log[s+i] : 'x, exp_a[i]); else passed++;
    end
    checks++; if ((irq_cnt[0] - i0 >= 2) !== 1'b1) $display("FAIL loop_irq: got %0d want >=2", irq_cnt[0] - i0); else passed++;
    csr_rd(ra(0, 0), d);
    checks++; if ((d & 32'h5) !== 32'h5) $display("FAIL loop_en_kept: got %h want en|loop set", d); else passed++;
    csr_wr(ra(0, 0), 32'h0);
    repeat (10) tick();
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    int s = wb_log.size();
    int ss;
    out_ready = 1'b0;
    csr_wr(ra(0, 1), 32'h700);
    csr_wr(ra(0, 2), 32'd3);
    csr_wr(ra(0, 0), 32'h1);
    wait_log(s + 2, 100, "rst_fill");
    stall = 1'b1;
    wait_stb(20, "rst_stb");
    checks++; if (out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", out_valid); else passed++;
    sys_rst = 1'b1;
    tick();
    checks++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) $display("FAIL rst_cyc_stb: got %b want 00", {wbm_cyc_o, wbm_stb_o}); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
    sys_rst = 1'b0;
    force_ack = 1'b1;
    out_ready = 1'b1;
    ss = st_log.size();
    tick(); tick();
    force_ack = 1'b0;
    stall = 1'b0;
    tick();
    checks++; if ({out_valid, wbm_cyc_o} !== 2'b00 || st_log.size() !== ss) $display("FAIL rst_late_ack: got valid=%b cyc=%b pops=%0d want 0 0 0", out_valid, wbm_cyc_o, st_log.size() - ss); else passed++;
    csr_rd(ra(0, 0), d);
    checks++; if (d !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", d); else passed++;
    csr_rd(ra(0, 1), d);
    checks++; if (d !== 32'h0) $display("FAIL rst_addr: got %h want 0", d); else passed++;
    csr_rd(ra(0, 2), d);
    checks++; if (d !== 32'h0) $display("FAIL rst_remain: got %h want 0", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_csr();
    test_single();
    test_round_robin();
    test_backpressure();
    test_disable_mid();
    test_en_no_remain();
`ifdef AUDIO_DMA_LOOP_EN
    test_loop();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/audio_dma_reader.md
Name: audio_dma_reader

Overview:
- Parametrised multi-channel DMA read engine for the audio subsystem; generalises the single downstream DMA reader of the AC'97 core to NCHAN independent playback channels.
- Each channel fetches 32-bit words from memory over a WISHBONE classic master into one shared sample FIFO.
- Each word is tagged with its channel number on a valid/ready output stream feeding the slot formatter.
- Configured through the standard CSR bus; per-channel completion interrupts.

Parameters:
- csr_addr, 4'h0, CSR page; block selected when csr_a[13:10] == csr_addr
- NCHAN, 2, number of channels, 1..4
- DEPTH, 16, shared FIFO depth in words, power of two, 4..64
- CW, 2, channel tag width, >= clog2(NCHAN) and >= 1

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- csr_a  in  14  CSR word address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  NCHAN  per-channel one-cycle completion pulse
- wbm_adr_o  out  32  WB address, word aligned (bits 1:0 = 0)
- wbm_cti_o  out  3  always 3'b000 (classic)
- wbm_we_o  out  1  constant 0
- wbm_cyc_o  out  1  WB cycle
- wbm_stb_o  out  1  WB strobe
- wbm_ack_i  in  1  WB acknowledge
- wbm_dat_i  in  32  WB read data
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_chan  out  CW  channel tag of head
- out_data  out  32  sample word of head

Behaviour:
- Reset: csr_do=0, irq=0, cyc/stb=0, wbm_adr_o=0, out_valid=0. All channel registers 0. FIFO empty. Round-robin pointer at channel 0.
- CSR map: channel n uses word offsets 4n+0, 4n+1, 4n+2.
  - 4n+0 CTRL: bit0 EN (rw), bit1 BUSY (ro, 1 while a WB cycle for n is in flight).
  - 4n+1 ADDR: rw, bits 1:0 forced 0.
  - 4n+2 REMAIN: rw, word count.
- CSR reads: csr_do valid the cycle after csr_a is presented. Reads 0 when the page is unselected or the offset is unmapped.
- Writes to ADDR/REMAIN while EN=1 are ignored.
- Channel n is eligible when EN=1 and REMAIN != 0.
- FSM IDLE -> FETCH -> IDLE:
  - IDLE: if FIFO free entries >= 1 and any channel is eligible, pick the next eligible channel in round-robin order after the last served one. Drive wbm_adr_o = ADDR[n] and assert cyc/stb on the next edge.
  - FETCH: hold cyc/stb until wbm_ack_i. On the ack edge:
    - push {n, wbm_dat_i} into the FIFO;
    - ADDR[n] += 4 (wraps modulo 2^32);
    - REMAIN[n] -= 1;
    - drop cyc/stb;
    - return to IDLE.
  - Minimum 1 idle cycle between WB cycles; one transaction outstanding at most.
- Completion: on the ack that brings REMAIN[n] to 0, clear EN[n] and pulse irq[n] for exactly one cycle.
- Enable written 0 mid-FETCH: the in-flight cycle completes normally (push, counters update), then no further fetches. irq fires only if REMAIN reaches 0.
- Enable written 1 with REMAIN=0: EN is set, the channel is never eligible, and no irq fires.
- FIFO:
  - Output is first-word-fall-through; a pop occurs when out_valid & out_ready.
  - A push and a pop in the same cycle are both honoured.
  - Full blocks new fetches only, never an in-flight ack, because one FIFO entry is reserved at issue.
- sys_rst mid-cycle: cyc/stb go low on the next edge; any late ack is ignored.

Optional Feature:
- Macro: AUDIO_DMA_LOOP_EN.
- With the macro defined:
  - Each channel adds a shadow base register (4n+3, rw) and CTRL bit2 LOOP.
  - When REMAIN hits 0 with LOOP=1: ADDR reloads from the base, REMAIN reloads from the value last written to REMAIN, EN stays 1, and irq still pulses. This gives circular buffers.
- Without the macro: offset 4n+3 reads 0, bit2 reads 0, and writes to both are ignored.

Decomposition:
- Package audio_dma_pkg: register offset constants (REG_CTRL=0, REG_ADDR=1, REG_REMAIN=2, REG_BASE=3), CTRL bit positions, WB CTI_CLASSIC=3'b000, FSM state enum.
- Sub-module audio_dma_fifo: synchronous FWFT FIFO, width CW+32, depth DEPTH, with full/empty/count outputs.

Test Plan:
- NCHAN=1: ADDR=0x100, REMAIN=3, EN=1. Expect WB reads at 0x100, 0x104, 0x108. Stream carries chan 0 with data equal to each address. irq[0] pulses once. CTRL reads 0.
- NCHAN=2: ch0 ADDR=0x1000 REMAIN=2, ch1 ADDR=0x2000 REMAIN=2, both enabled together. Expect WB order 0x1000, 0x2000, 0x1004, 0x2004 (round robin).
- DEPTH=4, out_ready=0, REMAIN=10. Expect exactly 4 WB reads, then cyc stays low. Raise out_ready and expect the remaining 6 reads to follow.
- Write EN=0 while BUSY=1. Expect that transaction to complete and REMAIN to drop by 1. No further WB cycles and no irq.
- Assert sys_rst while stb is high. Expect cyc/stb=0 on the next edge, all CSRs 0, and out_valid=0.
- With AUDIO_DMA_LOOP_EN: BASE=0x40, ADDR=0x40, REMAIN=2, LOOP=1. Expect reads 0x40, 0x44, 0x40, 0x44…, with irq each wrap and EN remaining 1.
